// File: rtl/frame_update_sequencer.sv
// Grants N update clients in turn, once per (divided) vertical blanking start.
// Optional request watchdog is enabled with `SEQ_WATCHDOG_EN.
module frame_update_sequencer #(
  parameter int V_DISPLAY = 480,
  parameter int N_CLIENTS = 4,
  parameter int FRAME_DIV = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 sys_clk_i,
  input  logic                 reset_i,
  input  logic [9:0]           y_i,
  input  logic                 enable_i,
  input  logic                 clr_i,
  output logic [N_CLIENTS-1:0] upd_req_o,
  input  logic [N_CLIENTS-1:0] upd_ack_i,
  output logic                 frame_tick_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic                 timeout_o,
  output logic [15:0]          frame_cnt_o
);

  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int DW = $clog2(FRAME_DIV + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CLIENTS - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(FRAME_DIV - 1);

  if (FRAME_DIV < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("frame_update_sequencer: FRAME_DIV and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [DW-1:0] div;
  logic          blank, blank_q;
  logic          ack_hit, start, wd_expire;

`ifdef SEQ_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;
`endif

  always_comb begin
    blank   = (y_i >= 10'(V_DISPLAY));
    ack_hit = upd_ack_i[idx];
    start   = frame_tick_o && enable_i && (state == S_IDLE) && (div == LAST_DIV);
`ifdef SEQ_WATCHDOG_EN
    // an ack on the expiry edge takes precedence over the timeout
    wd_expire = (wd_cnt == TW'(TIMEOUT - 1)) && !ack_hit;
`else
    wd_expire = 1'b0;
`endif
  end

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= S_IDLE;
      idx          <= '0;
      div          <= '0;
      blank_q      <= 1'b1;
      frame_tick_o <= 1'b0;
      upd_req_o    <= '0;
      busy_o       <= 1'b0;
      overrun_o    <= 1'b0;
      frame_cnt_o  <= '0;
`ifdef SEQ_WATCHDOG_EN
      timeout_o    <= 1'b0;
      wd_cnt       <= '0;
`endif
    end else begin
      blank_q      <= blank;
      frame_tick_o <= blank && !blank_q;

      if (clr_i) begin
        overrun_o <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
        timeout_o <= 1'b0;
`endif
      end

      if (frame_tick_o && enable_i && state == S_IDLE)
        div <= (div == LAST_DIV) ? '0 : div + 1'b1;

      // overrun pre-empts whatever the state machine would otherwise do
      if (!blank && state != S_IDLE) begin
        overrun_o <= 1'b1;
        upd_req_o <= '0;
        busy_o    <= 1'b0;
        state     <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            state     <= S_REQ;
            idx       <= '0;
            upd_req_o <= N_CLIENTS'(1);
            busy_o    <= 1'b1;
`ifdef SEQ_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
          end
          S_REQ: if (ack_hit || wd_expire) begin
`ifdef SEQ_WATCHDOG_EN
            wd_cnt <= '0;
            if (wd_expire) timeout_o <= 1'b1;
`endif
            if (idx == LAST_IDX) begin
              state     <= S_DONE;
              upd_req_o <= '0;
            end else begin
              idx       <= idx + 1'b1;
              upd_req_o <= upd_req_o << 1;
            end
          end else begin
`ifdef SEQ_WATCHDOG_EN
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
          S_DONE: begin
            frame_cnt_o <= frame_cnt_o + 16'd1;
            busy_o      <= 1'b0;
            state       <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifndef SEQ_WATCHDOG_EN
  assign timeout_o = 1'b0;
`endif

endmodule
